fetch_stage: RTL and testbench

Instruction fetch unit and IF/ID pipeline register for the 20-bit SIMD AES core. It owns the program counter and issues word reads to the synchronous instruction memory. It buffers returned words across stalls and presents `instr_id`, `pc_id` and `valid_id` to the decode stage, where the Controller consumes `instr_id` as `Instruction`. Branch redirects from execute flush in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the IF/ID record handed to the decode stage.
package fetch_pkg;

  localparam int FETCH_BITS     = 20;
  localparam int FETCH_PC_W     = 10;
  localparam int FETCH_RESET_PC = 0;

  typedef struct packed {
    logic [FETCH_BITS-1:0] instr;
    logic [FETCH_PC_W-1:0] pc;
    logic                  valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a word that returns from memory while decode is stalled.
module fetch_skid_buf #(
  parameter int BITS = 20,
  parameter int PC_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [BITS-1:0] instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  output logic [BITS-1:0] instr_o,
  output logic [PC_W-1:0] pc_o
);

  logic            valid_q;
  logic [BITS-1:0] instr_q;
  logic [PC_W-1:0] pc_q;

  // Clear (flush or reset) dominates a simultaneous load so a flushed word never survives.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register; define FETCH_PERF_CNT_EN to add perf counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int BITS     = FETCH_BITS,
  parameter int PC_W     = FETCH_PC_W,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [BITS-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [BITS-1:0] instr_id,
  output logic [PC_W-1:0] pc_id,
  output logic            valid_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [BITS-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_id_q, pc_id_d;
  logic            valid_q, valid_d;
  logic            load_valid;

  logic            hold_load, hold_drain, hold_clear;
  logic            hold_valid;
  logic [BITS-1:0] hold_instr;
  logic [PC_W-1:0] hold_pc;

  assign imem_rd_en = !rst && !stall && !branch_taken;
  assign imem_addr  = pc_q;

  // Flush outranks stall; the held word drains before any in-flight word can arrive.
  always_comb begin
    pc_d       = pc_q;
    req_d      = 1'b0;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    pc_id_d    = pc_id_q;
    valid_d    = valid_q;
    load_valid = 1'b0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_clear = 1'b0;

    if (imem_rd_en) begin
      pc_d     = pc_q + 1'b1;
      req_d    = 1'b1;
      req_pc_d = pc_q;
    end

    if (branch_taken) begin
      pc_d       = branch_target;
      valid_d    = 1'b0;
      hold_clear = 1'b1;
    end else if (stall) begin
      hold_load = req_q;
    end else if (hold_valid) begin
      instr_d    = hold_instr;
      pc_id_d    = hold_pc;
      valid_d    = 1'b1;
      load_valid = 1'b1;
      hold_drain = 1'b1;
    end else if (req_q) begin
      instr_d    = imem_rdata;
      pc_id_d    = req_pc_q;
      valid_d    = 1'b1;
      load_valid = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= PC_W'(RESET_PC);
      req_q    <= 1'b0;
      req_pc_q <= '0;
      instr_q  <= '0;
      pc_id_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      valid_q  <= valid_d;
    end
  end

  fetch_skid_buf #(
    .BITS (BITS),
    .PC_W (PC_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .clear_i (hold_clear),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (hold_valid),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  assign instr_id = instr_q;
  assign pc_id    = pc_id_q;
  assign valid_id = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q, flush_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      if (load_valid && (fetched_q != '1)) fetched_q <= fetched_q + 1'b1;
      if (stall && (stall_q != '1))        stall_q   <= stall_q + 1'b1;
      if (branch_taken && (flush_q != '1)) flush_q   <= flush_q + 1'b1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_flush   = flush_q;
`else
  logic unusedLoadValid;
  assign unusedLoadValid = load_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stall/flush/wrap/reset scenarios against a preloaded memory.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic        imem_rd_en;
  logic [19:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic [19:0] instr_id;
  logic [9:0]  pc_id;
  logic        valid_id;

  logic [19:0] mem [0:1023];
  logic [9:0]  expQ [$];
  int          vectorsApplied = 0;
  int          miscompares    = 0;
  int          cycNum         = 0;
  int          base           = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_id      (instr_id),
    .pc_id         (pc_id),
    .valid_id      (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycNum <= cycNum + 1;

  // Synchronous instruction memory: data for an issued address returns one cycle later.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycNum - base);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [9:0] t);
    rst           = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  // Advance to just after the rising edge that starts cycle k (relative to base).
  task automatic goCycle(input int k);
    while (cycNum < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushRange(input logic [9:0] first, input int count);
    logic [9:0] p;
    p = first;
    for (int i = 0; i < count; i++) begin
      expQ.push_back(p);
      p = p + 10'd1;
    end
  endtask

  // A word is consumed by decode when it is presented valid and not held by stall.
  always @(negedge clk) begin
    if (!rst && valid_id && !stall) begin
      if (expQ.size() == 0) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL unexpectedWord: got pc_id %h instr_id %h, expected no word", pc_id, instr_id);
      end else begin
        logic [9:0]  ePc;
        logic [19:0] eInstr;
        ePc    = expQ.pop_front();
        eInstr = 20'(ePc) + 20'h00100;
        checkOutput("streamPc", 32'(pc_id), 32'(ePc));
        checkOutput("streamInstr", 32'(instr_id), 32'(eInstr));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 20'(k) + 20'h00100;
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    repeat (3) @(posedge clk);

    @(negedge clk);
    checkOutput("resetValid", 32'(valid_id), 32'd0);
    checkOutput("resetInstr", 32'(instr_id), 32'd0);
    checkOutput("resetPcId", 32'(pc_id), 32'd0);
    checkOutput("resetAddr", 32'(imem_addr), 32'd0);
    checkOutput("resetRdEn", 32'(imem_rd_en), 32'd0);

    // Straight-line fetch, then a 3-cycle stall while address 5 is in flight.
    pushRange(10'h000, 10);
    @(posedge clk);
    #1;
    base = cycNum;
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("firstRdEn", 32'(imem_rd_en), 32'd1);
    checkOutput("firstAddr", 32'(imem_addr), 32'd0);
    goCycle(1);
    @(negedge clk);
    checkOutput("latencyBubble", 32'(valid_id), 32'd0);

    goCycle(6);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("stallAddr", 32'(imem_addr), 32'd6);
    goCycle(7);
    @(negedge clk);
    checkOutput("stallHoldInstr", 32'(instr_id), 32'h00104);
    checkOutput("stallHoldValid", 32'(valid_id), 32'd1);
    goCycle(9);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);

    // Steady-state redirect to 0x040: two bubbles, then the target.
    pushRange(10'h040, 4);
    goCycle(14);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h040);
    goCycle(15);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("flushBubble1", 32'(valid_id), 32'd0);
    goCycle(16);
    @(negedge clk);
    checkOutput("flushBubble2", 32'(valid_id), 32'd0);
    goCycle(17);
    @(negedge clk);
    checkOutput("flushTargetPc", 32'(pc_id), 32'h040);
    checkOutput("flushTargetValid", 32'(valid_id), 32'd1);

    // Redirect near the top of the address space to exercise PC wrap.
    expQ.push_back(10'h3FE);
    expQ.push_back(10'h3FF);
    pushRange(10'h000, 3);
    goCycle(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h3FE);
    goCycle(21);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    goCycle(25);
    @(negedge clk);
    checkOutput("wrapPc", 32'(pc_id), 32'h000);

    // Fill the skid buffer, then flush while still stalled: held word 0x004 must vanish.
    pushRange(10'h080, 2);
    goCycle(28);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    goCycle(29);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h080);
    goCycle(30);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("stallFlushBubble1", 32'(valid_id), 32'd0);
    goCycle(31);
    @(negedge clk);
    checkOutput("stallFlushBubble2", 32'(valid_id), 32'd0);
    goCycle(32);
    @(negedge clk);
    checkOutput("stallFlushPc", 32'(pc_id), 32'h080);

    // Fill the skid buffer, then reset mid-stream; fetch restarts from word 0.
    pushRange(10'h000, 6);
    goCycle(34);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    goCycle(35);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h000);
    goCycle(36);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("midResetValid", 32'(valid_id), 32'd0);
    checkOutput("midResetAddr", 32'(imem_addr), 32'd0);
    checkOutput("midResetRdEn", 32'(imem_rd_en), 32'd0);
    checkOutput("midResetPcId", 32'(pc_id), 32'd0);
    goCycle(37);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h000);
    goCycle(45);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h000);
    goCycle(48);
    @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
